snake_body: RTL and testbench
=============================

# snake_body

Snake body store and segment streamer for the snake game. Holds the head position, the snake length and a ring buffer of per-segment link directions. Walks the body continuously, one segment per clock from head to tail, and feeds the `snake_*` stream consumed by the `vga` renderer's row buffer. Applies movement and growth requests from the game controller at walk boundaries, and detects wall and self collisions.

## Interface

Parameters:
- `GAME_WIDTH`, default 18: playfield columns, valid x = 1..GAME_WIDTH.
- `GAME_HEIGHT`, default 13: playfield rows, valid y = 1..GAME_HEIGHT.
- `MAX_LENGTH`, default 64: maximum segment count, a power of two.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous active-low reset.
- `game_rst_n` in 1: synchronous active-low game restart.
- `step` in 1: one-cycle move request.
- `step_dir` in 2: move direction. 0 = up (y−1), 1 = down (y+1), 2 = left (x−1), 3 = right (x+1).
- `grow` in 1: sampled with `step`; the snake grows by one on this move.
- `snake_head_x` out 5, `snake_head_y` out 4: current head tile.
- `snake_x` out 5, `snake_y` out 4: tile of the streamed segment.
- `snake_dir` out 2: direction from the streamed segment toward the next segment (toward the tail).
- `snake_first` out 1: streamed segment is the head.
- `snake_last` out 1: streamed segment is the tail.
- `snake_valid` out 1: stream word is valid.
- `length` out 7: current segment count, 1..MAX_LENGTH.
- `failure` out 1: latched collision.
- `success` out 1: latched; `length` == MAX_LENGTH.

## Operation

Storage:
- `link[MAX_LENGTH]` holds 2-bit flops. `link[(hp+i) mod MAX_LENGTH]` is the direction from segment i to segment i+1.
- `hp` is the head pointer, log2(MAX_LENGTH) bits, and wraps modulo MAX_LENGTH.

Restart (`rst_n` low, or `game_rst_n` low at a clock edge):
- head = (4,7), `length` = 3, `hp` = 0.
- `link[0]` = `link[1]` = 2 (left).
- pending cleared, `failure` = `success` = 0, walker in IDLE.

Walker:
- States are IDLE and WALK.
- IDLE goes to WALK on the first cycle with `game_rst_n` high.
- In WALK, index k runs 0..length−1. Each cycle outputs:
  - position = head advanced through links 0..k−1;
  - `snake_dir` = `link[hp+k]`;
  - `snake_first` = (k==0);
  - `snake_last` = (k==length−1).
- After k = length−1, k returns to 0 with no gap cycle.
- `length` = 1: both `snake_first` and `snake_last` are high.

Step requests:
- `step` sets pending with `pend_dir` = `step_dir`. `grow` is ORed into `pend_grow`.
- A later `step` before apply overwrites `pend_dir` (latest wins) and keeps the OR of `grow`.
- Reversal: if `step_dir` is the opposite of the current heading, it is replaced by the current heading. Current heading = opposite of `link[hp]`, where opposite(d) = {d[1], ~d[0]}.

Apply (on the edge ending the k = length−1 cycle, pending set, `failure` 0):
- new head = head + `pend_dir`.
- If the new head leaves 1..GAME_WIDTH or 1..GAME_HEIGHT: `failure` set, head, `hp` and `length` unchanged.
- Otherwise:
  - `hp` −= 1;
  - `link[hp_new]` = opposite(`pend_dir`);
  - head = new head;
  - if `pend_grow` and `length` < MAX_LENGTH, `length` += 1;
  - `success` set when `length` becomes MAX_LENGTH.
- Pending is cleared in both cases.

Self collision:
- During WALK, any segment with k ≥ 1 whose position equals the head sets a hit flag.
- On the last cycle of that walk, a set hit flag sets `failure`; the flag clears at walk start.

After `failure`:
- steps are ignored;
- walking continues unchanged;
- `failure` clears only on restart.

## Timing

- Reset values: all outputs 0, except:
  - `length` = 3;
  - `snake_head_x` = 4, `snake_head_y` = 7.
- `snake_valid` = 0 in IDLE and goes to 1 on the first WALK cycle.
- All outputs are registered; stream words change every clock.
- Walk period = `length` cycles.
- Step-to-effect latency is 1 to length+1 cycles. The new head appears on the `snake_first` word following apply.
- A `step` in the same cycle as an apply edge is not part of that apply; it becomes pending for the next walk.
- `game_rst_n` low mid-walk aborts the walk. The next cycle is IDLE with `snake_valid` 0.

## Test plan

- Reset, release: stream repeats (4,7,d2,first), (3,7,d2), (2,7,last). `snake_valid` is first high 1 cycle after `game_rst_n` high.
- `step` dir 3 without grow: next walk yields (5,7,d2,first), (4,7), (3,7,last). `length` stays 3.
- `step` dir 0 with grow: head (4,6), first word `snake_dir` = 1. `length` = 4, tail is (2,7).
- `step` dir 2 (reversal of heading right): treated as right, head (5,7). `failure` stays 0.
- Steer head to x = GAME_WIDTH, then `step` dir 3: `failure` = 1 and head is unchanged. A later `step` is ignored; `game_rst_n` pulse clears `failure`.
- Grow to length 5, then steps up, left, down (head re-enters its own body): `failure` is set at the end of the following walk. Grow to MAX_LENGTH: `success` = 1, and a further grow leaves `length` = MAX_LENGTH.

Source files
------------

// File: rtl/snake_body.sv
// Snake body store and segment streamer: head, length and a ring of link directions,
// walked head-to-tail one segment per clock, with move/grow and collision handling.
module snake_body #(
    parameter int GAME_WIDTH  = 18,
    parameter int GAME_HEIGHT = 13,
    parameter int MAX_LENGTH  = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       game_rst_n,
    input  logic       step,
    input  logic [1:0] step_dir,
    input  logic       grow,
    output logic [4:0] snake_head_x,
    output logic [3:0] snake_head_y,
    output logic [4:0] snake_x,
    output logic [3:0] snake_y,
    output logic [1:0] snake_dir,
    output logic       snake_first,
    output logic       snake_last,
    output logic       snake_valid,
    output logic [6:0] length,
    output logic       failure,
    output logic       success
);
    localparam int              PW = $clog2(MAX_LENGTH);
    localparam logic [4:0]      GW = 5'(GAME_WIDTH);
    localparam logic [3:0]      GH = 4'(GAME_HEIGHT);
    localparam logic [6:0]      ML = 7'(MAX_LENGTH);
    localparam logic [MAX_LENGTH-1:0][1:0] LINK_INIT = {{(MAX_LENGTH-2){2'b00}}, 2'b10, 2'b10};

    typedef enum logic {IDLE, WALK} state_t;

    state_t                       state_q, state_d;
    logic [4:0]                   hx_q, hx_d, sx_q, sx_d, nx;
    logic [3:0]                   hy_q, hy_d, sy_q, sy_d, ny;
    logic [6:0]                   len_q, len_d, k_q, k_d;
    logic [PW-1:0]                hp_q, hp_d;
    logic [MAX_LENGTH-1:0][1:0]   link_q, link_d;
    logic [1:0]                   pdir_q, pdir_d, sdir_q, sdir_d, heading, dir_in;
    logic                         pend_q, pend_d, pgrow_q, pgrow_d;
    logic                         fail_q, fail_d, succ_q, succ_d, hit_q, hit_d;
    logic                         first_q, first_d, last_q, last_d, vld_q, vld_d;
    logic                         walk_end, do_apply, in_bounds, cur_match;

    function automatic logic [1:0] opp(input logic [1:0] d);
        return {d[1], ~d[0]};
    endfunction

    function automatic logic [8:0] mv(input logic [4:0] x, input logic [3:0] y, input logic [1:0] d);
        case (d)
            2'd0:    return {x, y - 4'd1};
            2'd1:    return {x, y + 4'd1};
            2'd2:    return {x - 5'd1, y};
            default: return {x + 5'd1, y};
        endcase
    endfunction

    always_comb begin
        state_d = state_q; hx_d = hx_q; hy_d = hy_q; len_d = len_q; hp_d = hp_q;
        link_d = link_q; pend_d = pend_q; pdir_d = pdir_q; pgrow_d = pgrow_q;
        fail_d = fail_q; succ_d = succ_q; hit_d = hit_q; k_d = k_q;
        sx_d = sx_q; sy_d = sy_q; sdir_d = sdir_q; first_d = first_q; last_d = last_q; vld_d = vld_q;

        heading   = opp(link_q[hp_q]);
        dir_in    = (step_dir == opp(heading)) ? heading : step_dir;
        {nx, ny}  = mv(hx_q, hy_q, pdir_q);
        in_bounds = (nx >= 5'd1) && (nx <= GW) && (ny >= 4'd1) && (ny <= GH);
        walk_end  = (state_q == WALK) && last_q;
        do_apply  = walk_end && pend_q && !fail_q;
        cur_match = vld_q && !first_q && (sx_q == hx_q) && (sy_q == hy_q);

        // Self-hit accumulates over one walk and is judged on its last word.
        hit_d = hit_q | cur_match;
        if (walk_end) begin
            hit_d = 1'b0;
            if (hit_q || cur_match) fail_d = 1'b1;
        end

        if (do_apply) begin
            pend_d  = 1'b0;
            pgrow_d = 1'b0;
            if (!in_bounds) begin
                fail_d = 1'b1;
            end else begin
                hp_d         = hp_q - 1'b1;
                link_d[hp_d] = opp(pdir_q);
                hx_d         = nx;
                hy_d         = ny;
                if (pgrow_q && (len_q < ML)) begin
                    len_d = len_q + 7'd1;
                    if (len_d == ML) succ_d = 1'b1;
                end
            end
        end

        // A step on the apply edge lands in the freshly cleared pending slot.
        if (step && !fail_q) begin
            pend_d  = 1'b1;
            pdir_d  = dir_in;
            pgrow_d = pgrow_d | grow;
        end

        if (state_q == IDLE) begin
            state_d = WALK; k_d = 7'd0; vld_d = 1'b1;
            sx_d = hx_q; sy_d = hy_q; sdir_d = link_q[hp_q];
            first_d = 1'b1; last_d = (len_q == 7'd1);
        end else if (last_q) begin
            k_d = 7'd0;
            sx_d = hx_d; sy_d = hy_d; sdir_d = link_d[hp_d];
            first_d = 1'b1; last_d = (len_d == 7'd1);
        end else begin
            k_d = k_q + 7'd1;
            {sx_d, sy_d} = mv(sx_q, sy_q, sdir_q);
            sdir_d  = link_q[hp_q + k_d[PW-1:0]];
            first_d = 1'b0;
            last_d  = (k_d == len_q - 7'd1);
        end

        if (!game_rst_n) begin
            state_d = IDLE; hx_d = 5'd4; hy_d = 4'd7; len_d = 7'd3; hp_d = '0;
            link_d = LINK_INIT; pend_d = 1'b0; pdir_d = 2'd0; pgrow_d = 1'b0;
            fail_d = 1'b0; succ_d = 1'b0; hit_d = 1'b0; k_d = 7'd0;
            sx_d = 5'd0; sy_d = 4'd0; sdir_d = 2'd0; first_d = 1'b0; last_d = 1'b0; vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE; hx_q <= 5'd4; hy_q <= 4'd7; len_q <= 7'd3; hp_q <= '0;
            link_q <= LINK_INIT; pend_q <= 1'b0; pdir_q <= 2'd0; pgrow_q <= 1'b0;
            fail_q <= 1'b0; succ_q <= 1'b0; hit_q <= 1'b0; k_q <= 7'd0;
            sx_q <= 5'd0; sy_q <= 4'd0; sdir_q <= 2'd0; first_q <= 1'b0; last_q <= 1'b0; vld_q <= 1'b0;
        end else begin
            state_q <= state_d; hx_q <= hx_d; hy_q <= hy_d; len_q <= len_d; hp_q <= hp_d;
            link_q <= link_d; pend_q <= pend_d; pdir_q <= pdir_d; pgrow_q <= pgrow_d;
            fail_q <= fail_d; succ_q <= succ_d; hit_q <= hit_d; k_q <= k_d;
            sx_q <= sx_d; sy_q <= sy_d; sdir_q <= sdir_d; first_q <= first_d; last_q <= last_d; vld_q <= vld_d;
        end
    end

    assign snake_head_x = hx_q;
    assign snake_head_y = hy_q;
    assign snake_x      = sx_q;
    assign snake_y      = sy_q;
    assign snake_dir    = sdir_q;
    assign snake_first  = first_q;
    assign snake_last   = last_q;
    assign snake_valid  = vld_q;
    assign length       = len_q;
    assign failure      = fail_q;
    assign success      = succ_q;
endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body: stream contents, moves, growth, reversal, wall/self hits, success.
module tb_snake_body;
    logic       clk = 1'b0, rst_n = 1'b0, game_rst_n = 1'b0, step = 1'b0, grow = 1'b0;
    logic [1:0] step_dir = 2'd0;
    logic [4:0] snake_head_x, snake_x;
    logic [3:0] snake_head_y, snake_y;
    logic [1:0] snake_dir;
    logic       snake_first, snake_last, snake_valid, failure, success;
    logic [6:0] length;
    int         n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    snake_body dut (
        .clk(clk), .rst_n(rst_n), .game_rst_n(game_rst_n), .step(step), .step_dir(step_dir),
        .grow(grow), .snake_head_x(snake_head_x), .snake_head_y(snake_head_y),
        .snake_x(snake_x), .snake_y(snake_y), .snake_dir(snake_dir), .snake_first(snake_first),
        .snake_last(snake_last), .snake_valid(snake_valid), .length(length),
        .failure(failure), .success(success)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One stream word {valid,x,y,dir,first,last}, then advance a clock.
    task automatic word(input string tag, input int x, input int y, input int d, input int f, input int l);
        chk(tag, 32'({snake_valid, snake_x, snake_y, snake_dir, snake_first, snake_last}),
                 32'({1'b1, 5'(x), 4'(y), 2'(d), 1'(f), 1'(l)}));
        tick();
    endtask

    task automatic chk_head(input string tag, input int x, input int y);
        chk(tag, 32'({snake_head_x, snake_head_y}), 32'({5'(x), 4'(y)}));
    endtask

    task automatic wait_first();
        int n = 0;
        while (!(snake_valid && snake_first) && n < 300) begin tick(); n++; end
        if (n >= 300) chk("timeout_first", 32'(snake_first), 32'd1);
    endtask

    task automatic wait_last();
        int n = 0;
        while (!(snake_valid && snake_last) && n < 300) begin tick(); n++; end
        if (n >= 300) chk("timeout_last", 32'(snake_last), 32'd1);
    endtask

    // Issue a step on a head word; return on the head word after the apply edge.
    task automatic do_step(input logic [1:0] d, input logic g);
        wait_first();
        step = 1'b1; step_dir = d; grow = g;
        tick();
        step = 1'b0; grow = 1'b0;
        wait_last();
        tick();
    endtask

    task automatic chk_period(input string tag, input int exp);
        int n = 0;
        wait_first();
        do begin tick(); n++; end while (!snake_first && n < 200);
        chk(tag, 32'(n), 32'(exp));
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_stream", 32'({snake_valid, snake_first, snake_last, snake_x, snake_y, snake_dir, failure, success}), 32'd0);
        chk("rst_len", 32'(length), 32'd3);
        chk_head("rst_head", 4, 7);

        rst_n = 1'b1;
        tick(); tick();
        chk("idle_valid", 32'(snake_valid), 32'd0);
        game_rst_n = 1'b1;
        tick();
        word("w0", 4, 7, 2, 1, 0);
        word("w1", 3, 7, 2, 0, 0);
        word("w2", 2, 7, 0, 0, 1);
        word("w0_again", 4, 7, 2, 1, 0);
        chk_period("period3", 3);

        do_step(2'd3, 1'b0);
        word("r_w0", 5, 7, 2, 1, 0);
        word("r_w1", 4, 7, 2, 0, 0);
        word("r_w2", 3, 7, 2, 0, 1);
        chk("r_len", 32'(length), 32'd3);

        tick();
        game_rst_n = 1'b0;
        tick();
        chk("abort_valid", 32'(snake_valid), 32'd0);
        chk_head("abort_head", 4, 7);
        game_rst_n = 1'b1;
        tick();
        word("rs_w0", 4, 7, 2, 1, 0);

        do_step(2'd0, 1'b1);
        word("g_w0", 4, 6, 1, 1, 0);
        word("g_w1", 4, 7, 2, 0, 0);
        word("g_w2", 3, 7, 2, 0, 0);
        word("g_w3", 2, 7, 0, 0, 1);
        chk("g_len", 32'(length), 32'd4);

        do_step(2'd3, 1'b0);
        chk_head("turn_right", 5, 6);
        do_step(2'd2, 1'b0);
        chk_head("reversal", 6, 6);
        chk("reversal_fail", 32'(failure), 32'd0);

        for (int i = 0; i < 12; i++) do_step(2'd3, 1'b0);
        chk_head("at_wall", 18, 6);
        do_step(2'd3, 1'b0);
        chk("wall_fail", 32'(failure), 32'd1);
        chk_head("wall_head", 18, 6);
        chk("wall_word", 32'({snake_first, snake_x}), 32'({1'b1, 5'd18}));
        do_step(2'd0, 1'b0);
        chk_head("ignored_step", 18, 6);
        chk("still_walking", 32'(snake_valid), 32'd1);
        game_rst_n = 1'b0;
        tick();
        game_rst_n = 1'b1;
        chk("restart_fail", 32'(failure), 32'd0);
        chk_head("restart_head", 4, 7);

        do_step(2'd3, 1'b1);
        do_step(2'd3, 1'b1);
        chk("len5", 32'(length), 32'd5);
        chk_head("len5_head", 6, 7);
        do_step(2'd0, 1'b0);
        do_step(2'd2, 1'b0);
        do_step(2'd1, 1'b0);
        chk_head("self_head", 5, 7);
        chk("self_pre", 32'(failure), 32'd0);
        wait_last();
        tick();
        chk("self_fail", 32'(failure), 32'd1);

        game_rst_n = 1'b0;
        tick();
        game_rst_n = 1'b1;
        for (int i = 0; i < 61; i++) begin
            if (i < 14)      do_step(2'd3, 1'b1);
            else if (i < 15) do_step(2'd0, 1'b1);
            else if (i < 32) do_step(2'd2, 1'b1);
            else if (i < 33) do_step(2'd0, 1'b1);
            else if (i < 50) do_step(2'd3, 1'b1);
            else if (i < 51) do_step(2'd0, 1'b1);
            else             do_step(2'd2, 1'b1);
        end
        chk_head("max_head", 8, 4);
        chk("max_len", 32'(length), 32'd64);
        chk("max_success", 32'(success), 32'd1);
        chk_period("period64", 64);
        do_step(2'd2, 1'b1);
        chk_head("sat_head", 7, 4);
        chk("sat_len", 32'(length), 32'd64);
        chk("sat_flags", 32'({success, failure}), 32'b10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
